// File: rtl/led_puzzle_pkg.sv
// Shared types, defaults and helpers for the LED-matrix puzzle engine.
package led_puzzle_pkg;

   localparam int ROWS_DEF   = 8;
   localparam int COLS_DEF   = 8;
   localparam int NBTN_DEF   = 8;
   localparam int LVL_W_DEF  = 3;
   localparam int MASK_W_DEF = NBTN_DEF * ROWS_DEF * COLS_DEF;

   typedef enum logic {
      S_BLANK = 1'b0,
      S_LIT   = 1'b1
   } scan_state_e;

   // Default 8-button layout for an 8x8 board; one byte per (button,row), bit c = column c.
   //   btn0: row0 cols 0-2        btn4: row0 cols 3-5      btn7: row0 cols 6-7
   //   btn1: row0 cols 2-3, row1 cols 0-3 (overlaps btn0 on cell (0,2))
   //   btn2: row1 cols 4-7, row2 cols 0-3
   //   btn3: row2 cols 4-7, row3 all
   //   btn5: rows 4-5 all         btn6: rows 6-7 all
   function automatic logic [MASK_W_DEF-1:0] build_default_mask();
      logic [MASK_W_DEF-1:0] m;
      m = '0;
      m[(0*8 + 0)*8 +: 8] = 8'h07;
      m[(1*8 + 0)*8 +: 8] = 8'h0C;
      m[(1*8 + 1)*8 +: 8] = 8'h0F;
      m[(2*8 + 1)*8 +: 8] = 8'hF0;
      m[(2*8 + 2)*8 +: 8] = 8'h0F;
      m[(3*8 + 2)*8 +: 8] = 8'hF0;
      m[(3*8 + 3)*8 +: 8] = 8'hFF;
      m[(4*8 + 0)*8 +: 8] = 8'h38;
      m[(5*8 + 4)*8 +: 8] = 8'hFF;
      m[(5*8 + 5)*8 +: 8] = 8'hFF;
      m[(6*8 + 6)*8 +: 8] = 8'hFF;
      m[(6*8 + 7)*8 +: 8] = 8'hFF;
      m[(7*8 + 0)*8 +: 8] = 8'hC0;
      return m;
   endfunction

   localparam logic [MASK_W_DEF-1:0] DEFAULT_BTN_MASK = build_default_mask();

   // Rows that take part in the puzzle for a level: min(2*level+1, rows).
   function automatic int active_rows(input logic [31:0] lvl, input int rows);
      logic [31:0] t;
      t = (lvl << 1) + 32'd1;
      if (t > 32'(rows)) begin
         return rows;
      end else begin
         return int'(t);
      end
   endfunction

endpackage

// File: rtl/led_row_scanner.sv
// Row-multiplexed scan: each row slot is BLANK cycles dark, then lit for the rest of SCAN_DIV.
module led_row_scanner
   import led_puzzle_pkg::*;
#(
   parameter int ROWS     = ROWS_DEF,
   parameter int COLS     = COLS_DEF,
   parameter int SCAN_DIV = 1000,
   parameter int BLANK    = 2,
   parameter int RW       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            restart,
   input  logic [4:0]      act_rows,
   input  logic [COLS-1:0] board_row,
   output logic [RW-1:0]   row_idx,
   output logic [ROWS-1:0] rows_n,
   output logic [COLS-1:0] cols
);

   localparam int CNT_W   = $clog2(SCAN_DIV);
   localparam int LIT_LEN = SCAN_DIV - BLANK;

   scan_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RW-1:0]    row_q, row_d;
   logic [ROWS-1:0]  rows_n_q, rows_n_d;
   logic [COLS-1:0]  cols_q, cols_d;
   logic [4:0]       row_inc_s;

   // Next scan state, slot counter, row pointer and the registered drive values.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CNT_W'(1);
      row_d     = row_q;
      row_inc_s = 5'(row_q) + 5'd1;
      if (restart) begin
         state_d = S_BLANK;
         cnt_d   = '0;
         row_d   = '0;
      end else begin
         case (state_q)
            S_BLANK: begin
               if (cnt_q == CNT_W'(BLANK - 1)) begin
                  state_d = S_LIT;
                  cnt_d   = '0;
               end else begin
                  state_d = S_BLANK;
               end
            end
            S_LIT: begin
               if (cnt_q == CNT_W'(LIT_LEN - 1)) begin
                  state_d = S_BLANK;
                  cnt_d   = '0;
                  // Wrap at the active-row count; also catches a shrunken row count.
                  if (row_inc_s >= act_rows) begin
                     row_d = '0;
                  end else begin
                     row_d = row_inc_s[RW-1:0];
                  end
               end else begin
                  state_d = S_LIT;
               end
            end
            default: begin
               state_d = S_BLANK;
               cnt_d   = '0;
               row_d   = '0;
            end
         endcase
      end
      // board_row belongs to row_q, which equals row_d whenever state_d is S_LIT.
      rows_n_d = '1;
      cols_d   = '0;
      if (state_d == S_LIT) begin
         rows_n_d[row_d] = 1'b0;
         cols_d          = board_row;
      end else begin
         rows_n_d = '1;
         cols_d   = '0;
      end
   end

   // Scan state and output registers; reset blanks the matrix immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_BLANK;
         cnt_q    <= '0;
         row_q    <= '0;
         rows_n_q <= '1;
         cols_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         row_q    <= row_d;
         rows_n_q <= rows_n_d;
         cols_q   <= cols_d;
      end
   end

   assign row_idx = row_q;
   assign rows_n  = rows_n_q;
   assign cols    = cols_q;

endmodule

// File: rtl/led_puzzle_matrix_ctrl.sv
// Puzzle engine top: button sync/edge detect, board toggling, win detection, move counter.
module led_puzzle_matrix_ctrl
   import led_puzzle_pkg::*;
#(
   parameter int ROWS     = ROWS_DEF,
   parameter int COLS     = COLS_DEF,
   parameter int NBTN     = NBTN_DEF,
   parameter int LVL_W    = LVL_W_DEF,
   parameter int SCAN_DIV = 1000,
   parameter int BLANK    = 2,
   parameter logic [NBTN*ROWS*COLS-1:0] BTN_MASK = DEFAULT_BTN_MASK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NBTN-1:0]  btn,
   input  logic [LVL_W-1:0] level,
   input  logic             clear,
   output logic [ROWS-1:0]  rows_n,
   output logic [COLS-1:0]  cols,
   output logic             level_done,
   output logic             done_pulse,
   output logic [15:0]      moves
);

   localparam int CELLS = ROWS * COLS;
   localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic [NBTN-1:0]  btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d, btn_prev_q, btn_prev_d;
   logic [CELLS-1:0] board_q, board_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             level_done_q, level_done_d;
   logic             done_pulse_q, done_pulse_d;
   logic [15:0]      moves_q, moves_d;
   logic [NBTN-1:0]  rise_s;
   logic [CELLS-1:0] toggle_s;
   logic             restart_s, accept_s, win_s;
   logic [4:0]       act_rows_s;
   logic [RW-1:0]    row_idx_s;

   // Synchronizer, edge detect, board/move update and win evaluation.
   always_comb begin
      btn_s1_d   = btn;
      btn_s2_d   = btn_s1_q;
      btn_prev_d = btn_s2_q;
      level_d    = level;
      rise_s     = btn_s2_q & ~btn_prev_q;
      // Simultaneous presses combine by XOR, so a shared cell toggles twice and stays put.
      toggle_s = '0;
      for (int b = 0; b < NBTN; b++) begin
         if (rise_s[b]) begin
            toggle_s = toggle_s ^ BTN_MASK[b*CELLS +: CELLS];
         end else begin
            toggle_s = toggle_s;
         end
      end
      restart_s  = clear | (level != level_q);
      accept_s   = (|rise_s) & ~level_done_q;
      act_rows_s = 5'(active_rows(32'(level_q), ROWS));
      // Only rows below the active count must be fully lit.
      win_s = 1'b1;
      for (int r = 0; r < ROWS; r++) begin
         if ((5'(r) < act_rows_s) && (board_q[r*COLS +: COLS] != {COLS{1'b1}})) begin
            win_s = 1'b0;
         end else begin
            win_s = win_s;
         end
      end
      board_d = board_q;
      moves_d = moves_q;
      if (restart_s) begin
         board_d = '0;
         moves_d = '0;
      end else if (accept_s) begin
         board_d = board_q ^ toggle_s;
         if (moves_q != 16'hFFFF) begin
            moves_d = moves_q + 16'd1;
         end else begin
            moves_d = moves_q;
         end
      end else begin
         board_d = board_q;
         moves_d = moves_q;
      end
      if (restart_s) begin
         level_done_d = 1'b0;
      end else begin
         level_done_d = win_s;
      end
      done_pulse_d = level_done_d & ~level_done_q;
   end

   // State registers; the board lock is level_done_q itself.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_s1_q     <= '0;
         btn_s2_q     <= '0;
         btn_prev_q   <= '0;
         board_q      <= '0;
         level_q      <= '0;
         level_done_q <= 1'b0;
         done_pulse_q <= 1'b0;
         moves_q      <= 16'd0;
      end else begin
         btn_s1_q     <= btn_s1_d;
         btn_s2_q     <= btn_s2_d;
         btn_prev_q   <= btn_prev_d;
         board_q      <= board_d;
         level_q      <= level_d;
         level_done_q <= level_done_d;
         done_pulse_q <= done_pulse_d;
         moves_q      <= moves_d;
      end
   end

   led_row_scanner #(
      .ROWS     (ROWS),
      .COLS     (COLS),
      .SCAN_DIV (SCAN_DIV),
      .BLANK    (BLANK),
      .RW       (RW)
   ) u_scanner (
      .clk       (clk),
      .rst       (rst),
      .restart   (restart_s),
      .act_rows  (act_rows_s),
      .board_row (board_q[row_idx_s*COLS +: COLS]),
      .row_idx   (row_idx_s),
      .rows_n    (rows_n),
      .cols      (cols)
   );

   assign level_done = level_done_q;
   assign done_pulse = done_pulse_q;
   assign moves      = moves_q;

endmodule

// File: tb/tb_led_puzzle_matrix_ctrl.sv
// Directed and randomized checks of the puzzle engine against a cell-level reference model.
module tb_led_puzzle_matrix_ctrl;

   logic       clk;
   logic       rst;
   logic [7:0] btn;
   logic [2:0] level;
   logic       clear;
   logic [7:0] rows_n;
   logic [7:0] cols;
   logic       level_done;
   logic       done_pulse;
   logic [15:0] moves;

   int checks = 0;
   int errors = 0;
   int pulse_cnt = 0;

   // Reference model: one byte per row, plain counters.
   logic [7:0] m_board [8];
   int         m_moves;
   bit         m_done;
   int         m_level;

   led_puzzle_matrix_ctrl #(
      .SCAN_DIV (8),
      .BLANK    (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn        (btn),
      .level      (level),
      .clear      (clear),
      .rows_n     (rows_n),
      .cols       (cols),
      .level_done (level_done),
      .done_pulse (done_pulse),
      .moves      (moves)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst && done_pulse) pulse_cnt <= pulse_cnt + 1;
   end

   // Cells each button flips, listed per button.
   function automatic logic [7:0] mask_row(input int b, input int r);
      logic [7:0] v;
      v = 8'h00;
      case (b)
         0: if (r == 0) v = 8'h07;
         1: if (r == 0) v = 8'h0C; else if (r == 1) v = 8'h0F;
         2: if (r == 1) v = 8'hF0; else if (r == 2) v = 8'h0F;
         3: if (r == 2) v = 8'hF0; else if (r == 3) v = 8'hFF;
         4: if (r == 0) v = 8'h38;
         5: if (r == 4 || r == 5) v = 8'hFF;
         6: if (r == 6 || r == 7) v = 8'hFF;
         7: if (r == 0) v = 8'hC0;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   function automatic int m_active();
      return (2 * m_level + 1 > 8) ? 8 : 2 * m_level + 1;
   endfunction

   task automatic model_clear();
      for (int r = 0; r < 8; r++) m_board[r] = 8'h00;
      m_moves = 0;
      m_done  = 1'b0;
   endtask

   task automatic model_press(input logic [7:0] bset);
      logic [7:0] x;
      bit solved;
      if (!m_done && bset != 8'h00) begin
         for (int r = 0; r < 8; r++) begin
            x = 8'h00;
            for (int b = 0; b < 8; b++) if (bset[b]) x = x ^ mask_row(b, r);
            m_board[r] = m_board[r] ^ x;
         end
         if (m_moves < 65535) m_moves = m_moves + 1;
         solved = 1'b1;
         for (int r = 0; r < m_active(); r++) if (m_board[r] != 8'hFF) solved = 1'b0;
         m_done = solved;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [7:0] m, input int hold);
      btn = m;
      tick(hold);
      btn = 8'h00;
      tick(5);
   endtask

   // Wait (bounded) for row r to be lit and return the column drive.
   task automatic read_row(input int r, output logic [7:0] v);
      logic [7:0] want;
      bit found;
      want  = ~(8'h01 << r);
      found = 1'b0;
      v     = 8'h00;
      for (int i = 0; i < 300 && !found; i++) begin
         tick(1);
         if (rows_n === want) begin
            v     = cols;
            found = 1'b1;
         end
      end
      check("scan_row_found", 32'(found), 32'd1);
   endtask

   logic [7:0] rv;
   logic [7:0] rnd;
   logic [7:0] exp_rn;
   int         p0;
   int         mm;
   int         lvl;

   initial begin
      rst = 1'b0; btn = 8'h00; level = 3'd0; clear = 1'b0;
      m_level = 0;
      model_clear();
      #2 rst = 1'b1;
      #1;
      check("rst_rows_n", 32'(rows_n), 32'hFF);
      check("rst_cols", 32'(cols), 32'h00);
      check("rst_moves", 32'(moves), 32'd0);
      check("rst_done", 32'(level_done), 32'd0);
      check("rst_pulse", 32'(done_pulse), 32'd0);
      tick(2);
      rst = 1'b0;
      tick(3);

      // Held button toggles once.
      press(8'h01, 50); model_press(8'h01);
      read_row(0, rv);
      check("hold_row0", 32'(rv), 32'h07);
      check("hold_moves", 32'(moves), 32'd1);
      check("hold_done", 32'(level_done), 32'd0);

      // Solve level 0, then the locked board ignores presses.
      p0 = pulse_cnt;
      press(8'h10, 2); model_press(8'h10);
      press(8'h80, 3); model_press(8'h80);
      read_row(0, rv);
      check("solve_row0", 32'(rv), 32'hFF);
      check("solve_done", 32'(level_done), 32'd1);
      check("solve_pulses", 32'(pulse_cnt - p0), 32'd1);
      press(8'h02, 2); model_press(8'h02);
      check("locked_moves", 32'(moves), 32'd3);
      check("locked_model", 32'(moves), 32'(m_moves));
      read_row(0, rv);
      check("locked_row0", 32'(rv), 32'hFF);

      // Clear: no pulse, board and counters zeroed.
      clear = 1'b1; tick(1); clear = 1'b0; model_clear();
      tick(2);
      check("clr_moves", 32'(moves), 32'd0);
      check("clr_done", 32'(level_done), 32'd0);
      check("clr_pulses", 32'(pulse_cnt - p0), 32'd1);
      read_row(0, rv);
      check("clr_row0", 32'(rv), 32'h00);

      // Clear in the same cycle as the accepted edge wins.
      btn = 8'h01; tick(2);
      clear = 1'b1; tick(1); clear = 1'b0;
      btn = 8'h00; tick(5);
      check("clrpress_moves", 32'(moves), 32'd0);
      read_row(0, rv);
      check("clrpress_row0", 32'(rv), 32'h00);

      // Overlapping simultaneous presses cancel on the shared cell.
      press(8'h03, 2); model_press(8'h03);
      read_row(0, rv);
      check("overlap_row0", 32'(rv), 32'h0B);
      check("overlap_moves", 32'(moves), 32'd1);

      // Level 0 -> 1: restart and 3-row scan with 2 blank + 6 lit cycles per slot.
      level = 3'd1; m_level = 1; model_clear();
      mm = 0;
      for (int i = 0; i < 48; i++) begin
         tick(1);
         exp_rn = ((i % 8) < 2) ? 8'hFF : ~(8'h01 << ((i / 8) % 3));
         if (rows_n !== exp_rn) mm++;
      end
      check("scan_seq_mismatches", 32'(mm), 32'd0);
      check("lvl1_moves", 32'(moves), 32'd0);
      check("lvl1_done", 32'(level_done), 32'd0);
      for (int r = 0; r < 3; r++) begin
         read_row(r, rv);
         check("lvl1_row", 32'(rv), 32'h00);
      end

      // Level 1 -> 2 after some progress.
      press(8'h04, 1); model_press(8'h04);
      read_row(1, rv);
      check("lvl1_btn2_row1", 32'(rv), 32'(m_board[1]));
      check("lvl1_btn2_moves", 32'(moves), 32'd1);
      level = 3'd2; m_level = 2; model_clear();
      tick(2);
      check("lvl2_moves", 32'(moves), 32'd0);
      check("lvl2_done", 32'(level_done), 32'd0);
      for (int r = 0; r < 5; r++) begin
         read_row(r, rv);
         check("lvl2_row", 32'(rv), 32'(m_board[r]));
      end

      // Randomized rounds against the model.
      for (int rnd_i = 0; rnd_i < 4; rnd_i++) begin
         lvl = int'($urandom_range(0, 4));
         if (lvl != m_level) begin
            level = 3'(lvl);
            m_level = lvl;
         end else begin
            clear = 1'b1; tick(1); clear = 1'b0;
         end
         model_clear();
         tick(2);
         for (int k = 0; k < 8; k++) begin
            rnd = 8'($urandom_range(1, 255));
            press(rnd, int'($urandom_range(1, 4)));
            model_press(rnd);
            check("rand_moves", 32'(moves), 32'(m_moves));
            check("rand_done", 32'(level_done), 32'(m_done));
         end
         for (int r = 0; r < m_active(); r++) begin
            read_row(r, rv);
            check("rand_row", 32'(rv), 32'(m_board[r]));
         end
      end

      // Mid-operation reset blanks outputs at once.
      level = 3'd1; m_level = 1; model_clear();
      tick(2);
      press(8'h20, 2); model_press(8'h20);
      check("prerst_moves", 32'(moves), 32'd1);
      read_row(0, rv);
      #3 rst = 1'b1;
      #1;
      check("midrst_rows_n", 32'(rows_n), 32'hFF);
      check("midrst_cols", 32'(cols), 32'h00);
      check("midrst_moves", 32'(moves), 32'd0);
      check("midrst_done", 32'(level_done), 32'd0);
      tick(2);
      rst = 1'b0;
      tick(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
